pci_arbiter: RTL
================

Name: pci_arbiter

Overview:
- Central PCI bus arbiter: shares one AD/C_BE_/FRAME_/IRDY_ bus among N_MASTERS initiators (pci_master instances) via REQ_/GNT_ pairs.
- Round-robin fairness; bus parking on an idle bus; hidden arbitration during transfers.
- Revokes grants from masters that never start a cycle.
- Monitors FRAME_/IRDY_ only; drives nothing on the shared bus.

Parameters:
- N_MASTERS, 4: number of requesters, range 2..8.
- PARK_MASTER, 0: index granted when no one requests.
- IDLE_TIMEOUT, 16: idle-bus clocks a non-parked grantee gets to assert FRAME_.
- OWNER_W, $clog2(N_MASTERS): width of the owner index.

Ports:
- clk  in  1  bus clock; all logic on posedge.
- reset_  in  1  asynchronous, active-low reset.
- REQ_  in  N_MASTERS  per-master request, active low.
- FRAME_  in  1  bus FRAME_, active low.
- IRDY_  in  1  bus IRDY_, active low.
- GNT_  out  N_MASTERS  per-master grant, active low, registered, at most one bit low.
- owner  out  OWNER_W  index of the master owning the current transaction.
- owner_vld  out  1  high while in BUSY.
- parked  out  1  high when the current grant is a park grant.
- timeout  out  1  one-clock pulse when a grant is revoked for timeout.

Behaviour:
- Reset (async assert):
  - GNT_ = all 1s, owner = 0, owner_vld = 0, parked = 0, timeout = 0.
  - state = TA, rr_ptr = 0, idle_cnt = 0.
- Sampling: idle = FRAME_ & IRDY_; req = ~REQ_, both sampled at posedge.
- winner (combinational): first set bit of req, searching rr_ptr, rr_ptr+1, ... modulo N_MASTERS. Undefined (any = 0) when req == 0.
- TA (turnaround): GNT_ all 1s for exactly one clock.
  - Next: GRANT with g = winner, parked = 0, if any req.
  - Otherwise GRANT with g = PARK_MASTER, parked = 1.
- GRANT: GNT_[g] = 0.
  - idle == 0: BUSY, owner = g, rr_ptr = (g+1) mod N_MASTERS, idle_cnt = 0.
  - Else if parked and any req: if winner == g, clear parked and stay (no turnaround); else go to TA.
  - Else if !parked and !req[g] (request withdrawn): go to TA.
  - Else if !parked: increment idle_cnt. At idle_cnt == IDLE_TIMEOUT-1, pulse timeout, set rr_ptr = (g+1) mod N_MASTERS, go to TA.
- BUSY: owner_vld = 1; owner holds.
  - Hidden arbitration on each clock while idle == 0: if any req, g = winner, parked = 0; else g = PARK_MASTER, parked = 1.
  - GNT_ may move between masters with no turnaround cycle in this state.
  - The first clock idle == 1 is sampled: g is NOT recomputed, go to GRANT with the current g, idle_cnt = 0, owner_vld drops.
- GNT_ never changes from one master directly to another while the bus is idle; TA is mandatory in that case.
- Owner's REQ_ held continuously: it is still rotated out by rr_ptr when others request.
- Simultaneous timeout and FRAME_ assertion on the same clock: FRAME_ wins, goes to BUSY, no timeout pulse.
- idle_cnt width is $clog2(IDLE_TIMEOUT)+1; no wrap possible.

Decomposition:
- Package pci_arb_pkg:
  - state enum {TA, GRANT, BUSY}.
  - Default constants for N_MASTERS, PARK_MASTER, IDLE_TIMEOUT.
  - Function next_idx(idx, n) for the modulo increment.
- Sub-module pci_rr_picker: combinational round-robin winner.
  - Inputs: req, rr_ptr.
  - Outputs: winner, any.
  - Reused by other bus arbiters.

Test Plan (N_MASTERS=4, PARK_MASTER=0, IDLE_TIMEOUT=16):
- Reset with REQ_=4'b1111, then release -> GNT_=4'b1111 during reset and the first clock after; next clock GNT_=4'b1110, parked=1.
- Parked on 0, REQ_=4'b1011 -> TA clock with GNT_=1111, then GNT_=4'b1011, parked=0; drive FRAME_=0 -> owner=2, owner_vld=1.
- Masters 1 and 3 request continuously, each running 4-clock transactions -> owners alternate 1,3,1,3; no master wins twice in a row.
- Master 1 granted on an idle bus, never asserts FRAME_ -> GNT_[1] low exactly 16 clocks, timeout high one clock, GNT_=1111 one clock, then park on 0 (or the next winner).
- Master 0 in BUSY, REQ_[2] asserts -> GNT_=4'b1011 on the next edge while FRAME_=0; at the first idle sample go to GRANT on 2 with no TA clock.
- reset_ asserted mid-BUSY between clock edges -> GNT_=4'b1111 and owner_vld=0 immediately; after release, the normal reset sequence.

Source files
------------

// File: rtl/pci_arbiter_pkg.sv
// Shared types and helpers for the PCI bus arbiter family.
package pci_arb_pkg;

  typedef enum logic [1:0] {
    TA,
    GRANT,
    BUSY
  } arb_state_t;

  localparam int unsigned DEF_N_MASTERS    = 4;
  localparam int unsigned DEF_PARK_MASTER  = 0;
  localparam int unsigned DEF_IDLE_TIMEOUT = 16;

  // Modulo-n increment of a master index.
  function automatic int unsigned next_idx(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/pci_arbiter_if.sv
// Arbiter-facing bundle: request/grant pairs, bus idle monitors and status.
interface pci_arbiter_if #(
  parameter int unsigned N_MASTERS = 4,
  parameter int unsigned OWNER_W   = $clog2(N_MASTERS)
);
  logic [N_MASTERS-1:0] REQ_;
  logic                 FRAME_;
  logic                 IRDY_;
  logic [N_MASTERS-1:0] GNT_;
  logic [OWNER_W-1:0]   owner;
  logic                 owner_vld;
  logic                 parked;
  logic                 timeout;

  // Arbiter side.
  modport master (
    input  REQ_, FRAME_, IRDY_,
    output GNT_, owner, owner_vld, parked, timeout
  );

  // Bus / requester side.
  modport slave (
    output REQ_, FRAME_, IRDY_,
    input  GNT_, owner, owner_vld, parked, timeout
  );
endinterface

// File: rtl/pci_rr_picker.sv
// Combinational round-robin picker: first request at or after rr_ptr, wrapping.
module pci_rr_picker #(
  parameter int unsigned N = 4,
  parameter int unsigned W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] rr_ptr,
  output logic [W-1:0] winner,
  output logic         any
);

  localparam logic [W:0] N_W = (W+1)'(N);

  logic [W:0] idx;

  // Scan N positions starting at rr_ptr; the first hit wins.
  always_comb begin
    winner = '0;
    any    = 1'b0;
    idx    = '0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = {1'b0, rr_ptr} + (W+1)'(i);
      if (idx >= N_W) idx = idx - N_W;
      if (!any && req[idx[W-1:0]]) begin
        any    = 1'b1;
        winner = idx[W-1:0];
      end
    end
  end

endmodule

// File: rtl/pci_arbiter.sv
// Central PCI arbiter: round-robin grants, bus parking, hidden arbitration
// during transfers and revocation of grants that are never used.
module pci_arbiter
  import pci_arb_pkg::*;
#(
  parameter int unsigned N_MASTERS    = DEF_N_MASTERS,
  parameter int unsigned PARK_MASTER  = DEF_PARK_MASTER,
  parameter int unsigned IDLE_TIMEOUT = DEF_IDLE_TIMEOUT,
  parameter int unsigned OWNER_W      = $clog2(N_MASTERS)
) (
  input  logic          clk,
  input  logic          reset_,
  pci_arbiter_if.master bus
);

  localparam int unsigned        CNT_W    = $clog2(IDLE_TIMEOUT) + 1;
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(IDLE_TIMEOUT - 1);
  localparam logic [OWNER_W-1:0] PARK_IDX = OWNER_W'(PARK_MASTER);

  arb_state_t           state_q, state_d;
  logic [OWNER_W-1:0]   g_q, g_d;
  logic [N_MASTERS-1:0] gnt_q, gnt_d;
  logic                 parked_q, parked_d;
  logic [OWNER_W-1:0]   rr_q, rr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [OWNER_W-1:0]   owner_q, owner_d;
  logic                 vld_q, vld_d;
  logic                 tmo_q, tmo_d;
  logic                 gnt_on;

  logic [N_MASTERS-1:0] req;
  logic                 idle;
  logic [OWNER_W-1:0]   winner;
  logic                 any;
  logic [OWNER_W-1:0]   g_next;

  assign req    = ~bus.REQ_;
  assign idle   = bus.FRAME_ & bus.IRDY_;
  assign g_next = OWNER_W'(next_idx(32'(g_q), N_MASTERS));

  pci_rr_picker #(
    .N (N_MASTERS),
    .W (OWNER_W)
  ) u_picker (
    .req    (req),
    .rr_ptr (rr_q),
    .winner (winner),
    .any    (any)
  );

  // Next-state and next-output decode; GNT_ is rebuilt from g_d every clock.
  always_comb begin
    state_d  = state_q;
    g_d      = g_q;
    parked_d = parked_q;
    rr_d     = rr_q;
    cnt_d    = cnt_q;
    owner_d  = owner_q;
    vld_d    = 1'b0;
    tmo_d    = 1'b0;
    gnt_on   = 1'b1;
    unique case (state_q)
      TA: begin
        state_d = GRANT;
        cnt_d   = '0;
        if (any) begin
          g_d      = winner;
          parked_d = 1'b0;
        end else begin
          g_d      = PARK_IDX;
          parked_d = 1'b1;
        end
      end
      GRANT: begin
        // FRAME_ takes priority over every idle-bus rule, including timeout.
        if (!idle) begin
          state_d = BUSY;
          owner_d = g_q;
          rr_d    = g_next;
          cnt_d   = '0;
          vld_d   = 1'b1;
        end else if (parked_q) begin
          if (any) begin
            if (winner == g_q) begin
              parked_d = 1'b0;
            end else begin
              state_d = TA;
              gnt_on  = 1'b0;
            end
          end
        end else if (!req[g_q]) begin
          state_d = TA;
          gnt_on  = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
          tmo_d   = 1'b1;
          rr_d    = g_next;
          state_d = TA;
          gnt_on  = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      BUSY: begin
        if (!idle) begin
          vld_d = 1'b1;
          if (any) begin
            g_d      = winner;
            parked_d = 1'b0;
          end else begin
            g_d      = PARK_IDX;
            parked_d = 1'b1;
          end
        end else begin
          state_d = GRANT;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = TA;
        gnt_on  = 1'b0;
      end
    endcase
    gnt_d = '1;
    if (gnt_on) gnt_d[g_d] = 1'b0;
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q  <= TA;
      g_q      <= '0;
      gnt_q    <= '1;
      parked_q <= 1'b0;
      rr_q     <= '0;
      cnt_q    <= '0;
      owner_q  <= '0;
      vld_q    <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      g_q      <= g_d;
      gnt_q    <= gnt_d;
      parked_q <= parked_d;
      rr_q     <= rr_d;
      cnt_q    <= cnt_d;
      owner_q  <= owner_d;
      vld_q    <= vld_d;
      tmo_q    <= tmo_d;
    end
  end

  assign bus.GNT_      = gnt_q;
  assign bus.owner     = owner_q;
  assign bus.owner_vld = vld_q;
  assign bus.parked    = parked_q;
  assign bus.timeout   = tmo_q;

endmodule
